// File: rtl/al_accel_act_func_sched.sv
// al_accel_act_func_sched: streams a descriptor-defined scratchpad range through the
// combinational activation unit and writes results back, one element per cycle.
module al_accel_act_func_sched #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_src_addr,
    input  logic [ADDR_W-1:0] cfg_dst_addr,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [2:0]        cfg_typ,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_data,
    output logic [7:0]        act_func_di,
    output logic [2:0]        act_func_typ,
    input  logic [7:0]        act_func_do,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q, rd_idx, wr_idx;
    logic [2:0]        typ_q;
    logic [7:0]        di_q;
    logic              rd_v, wr_v, accept, last_rd, last_wr;
    always_comb begin
        cfg_ready    = state == IDLE;
        busy         = state != IDLE;
        done         = state == DONE;
        accept       = cfg_ready && cfg_valid;
        mem_rd_en    = state == RUN && enb;
        mem_rd_addr  = src_q + ADDR_W'(rd_idx);
        mem_wr_en    = wr_v;
        mem_wr_addr  = dst_q + ADDR_W'(wr_idx);
        mem_wr_data  = act_func_do;
        act_func_di  = di_q;
        act_func_typ = typ_q;
        last_rd      = mem_rd_en && rd_idx == len_q - LEN_W'(1);
        last_wr      = wr_v && wr_idx == len_q - LEN_W'(1);
        state_n      = state;
        case (state)
            IDLE:    state_n = accept ? (cfg_len != '0 ? RUN : DONE) : IDLE;
            RUN:     state_n = last_rd ? DRAIN : RUN;
            DRAIN:   state_n = last_wr ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    // rd_v/wr_v form the fixed two-cycle read-to-write pipeline; reset flushes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            typ_q  <= '0;
            rd_idx <= '0;
            wr_idx <= '0;
            rd_v   <= 1'b0;
            wr_v   <= 1'b0;
            di_q   <= '0;
        end else begin
            state <= state_n;
            rd_v  <= mem_rd_en;
            wr_v  <= rd_v;
            if (rd_v) di_q <= mem_rd_data;
            if (accept) begin
                src_q  <= cfg_src_addr;
                dst_q  <= cfg_dst_addr;
                len_q  <= cfg_len;
                typ_q  <= cfg_typ;
                rd_idx <= '0;
                wr_idx <= '0;
            end else begin
                if (mem_rd_en) rd_idx <= rd_idx + LEN_W'(1);
                if (wr_v) wr_idx <= wr_idx + LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_al_accel_act_func_sched.sv
// tb_al_accel_act_func_sched: randomized and directed jobs checked every cycle
// against a queue-based job model of the sequencer.
module tb_al_accel_act_func_sched;
    logic       clk = 0, reset = 1, enb = 1, cfg_valid = 0;
    logic [9:0] cfg_src_addr = 0, cfg_dst_addr = 0, cfg_len = 0;
    logic [2:0] cfg_typ = 0;
    logic       cfg_ready, mem_rd_en, mem_wr_en, busy, done;
    logic [9:0] mem_rd_addr, mem_wr_addr;
    logic [7:0] mem_rd_data = 0, mem_wr_data, act_func_di, act_func_do;
    logic [2:0] act_func_typ;
    logic [7:0] mem [1024];
    int n_cmp = 0, n_bad = 0, n_wr = 0, cyc = 0;

    al_accel_act_func_sched dut (
        .clk(clk), .reset(reset), .enb(enb), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr), .cfg_len(cfg_len),
        .cfg_typ(cfg_typ), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .act_func_di(act_func_di), .act_func_typ(act_func_typ),
        .act_func_do(act_func_do), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference activation unit: signed input, saturating piecewise approximations.
    function automatic logic [7:0] act(input logic [2:0] t, input logic [7:0] x);
        logic signed [7:0] s;
        s = x;
        case (t)
            3'd0:    return s < 0 ? 8'd0 : x;
            3'd1:    return s < 0 ? 8'd0 : (s > 6 ? 8'd6 : x);
            3'd2:    return {~x[7], x[7:1]};
            3'd3:    return s > 63 ? 8'h7F : (s < -64 ? 8'h80 : {x[6:0], 1'b0});
            default: return ~x;
        endcase
    endfunction

    assign act_func_do = act(act_func_typ, act_func_di);

    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) mem_rd_data <= mem[mem_rd_addr];
        if (mem_wr_en === 1'b1) begin
            mem[mem_wr_addr] <= mem_wr_data;
            n_wr <= n_wr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Job model: phase 0 idle, 1 active, 2 done pulse; pending writes are due two cycles after their read.
    typedef struct {int due; int idx;} wr_t;
    wr_t q[$];
    logic [7:0] snap [1024];
    int  m_ph = 0, m_src = 0, m_dst = 0, m_len = 0, m_rd = 0, m_typ = 0;
    int  m_acc = 0, m_done_cyc = 0, m_gap = 0;
    bit  m_live = 0, m_after_rst = 0, erd, ewr, lastw;

    always @(negedge clk) begin
        erd = m_ph == 1 && m_rd < m_len && enb;
        ewr = q.size() != 0 && q[0].due == cyc;
        if (m_live) begin
            chk("cfg_ready", 32'(cfg_ready), 32'(m_ph == 0));
            chk("busy", 32'(busy), 32'(m_ph != 0));
            chk("done", 32'(done), 32'(m_ph == 2));
            chk("rd_en", 32'(mem_rd_en), 32'(erd));
            chk("wr_en", 32'(mem_wr_en), 32'(ewr));
            chk("typ", 32'(act_func_typ), m_typ);
            if (erd) chk("rd_addr", 32'(mem_rd_addr), (m_src + m_rd) % 1024);
            if (ewr) begin
                chk("wr_addr", 32'(mem_wr_addr), (m_dst + q[0].idx) % 1024);
                chk("act_di", 32'(act_func_di), 32'(snap[q[0].idx]));
                chk("wr_data", 32'(mem_wr_data), 32'(act(3'(m_typ), snap[q[0].idx])));
            end
            if (m_after_rst) begin
                chk("rst_rd_addr", 32'(mem_rd_addr), 0);
                chk("rst_wr_addr", 32'(mem_wr_addr), 0);
                chk("rst_di", 32'(act_func_di), 0);
                chk("rst_wr_data", 32'(mem_wr_data), 0);
            end
            if (m_ph == 2) m_done_cyc = cyc;
        end
        if (reset) begin
            m_ph = 0; m_typ = 0; m_live = 1; m_after_rst = 1;
            q.delete();
        end else begin
            m_after_rst = 0;
            lastw = 0;
            if (ewr) begin
                lastw = q[0].idx == m_len - 1;
                void'(q.pop_front());
            end
            if (m_ph == 0) begin
                if (cfg_valid) begin
                    m_src = cfg_src_addr; m_dst = cfg_dst_addr; m_len = cfg_len; m_typ = cfg_typ;
                    m_rd = 0; m_gap = cyc - m_done_cyc; m_acc = cyc;
                    for (int i = 0; i < m_len; i++) snap[i] = mem[(m_src + i) % 1024];
                    m_ph = m_len == 0 ? 2 : 1;
                end
            end else if (m_ph == 1) begin
                if (erd) begin
                    q.push_back('{cyc + 2, m_rd});
                    m_rd++;
                end
                if (lastw) m_ph = 2;
            end else m_ph = 0;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int src, input int dst, input int len, input int typ);
        cfg_src_addr = 10'(src); cfg_dst_addr = 10'(dst); cfg_len = 10'(len); cfg_typ = 3'(typ);
        cfg_valid = 1;
        for (int i = 0; i < 300 && !cfg_ready; i++) tick();
        if (!cfg_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_done(input bit rnd);
        for (int i = 0; i < 400 && !done; i++) begin
            if (rnd) enb = $urandom_range(0, 3) != 0;
            tick();
        end
        if (!done) chk("done_timeout", 0, 1);
        enb = 1;
        tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, s, d;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        chk("act_relu6", 32'(act(3'd1, 8'h7F)), 32'h06);
        chk("act_tanh", 32'(act(3'd3, 8'hF0)), 32'hE0);
        chk("act_sigmoid", 32'(act(3'd2, 8'h00)), 32'h80);
        repeat (3) tick();
        reset = 0;
        tick();
        mem[10'h010] = 8'h05; mem[10'h011] = 8'hF0; mem[10'h012] = 8'h7F; mem[10'h013] = 8'h80;
        issue(10'h010, 10'h100, 4, 0);
        tick(); cfg_valid = 0;
        wait_done(0);
        chk("j1_done_lat", m_done_cyc - m_acc, 7);
        chk("j1_m100", 32'(mem[10'h100]), 32'h05);
        chk("j1_m101", 32'(mem[10'h101]), 32'h00);
        chk("j1_m102", 32'(mem[10'h102]), 32'h7F);
        chk("j1_m103", 32'(mem[10'h103]), 32'h00);
        w0 = n_wr;
        issue(10'h010, 10'h100, 4, 0);
        tick(); cfg_valid = 0;
        tick(); enb = 0;
        tick();
        tick(); enb = 1;
        wait_done(0);
        chk("stall_done_lat", m_done_cyc - m_acc, 9);
        chk("stall_writes", n_wr - w0, 4);
        mem[10'h3FE] = 8'h10; mem[10'h3FF] = 8'h20; mem[10'h000] = 8'h30; mem[10'h001] = 8'h40;
        issue(10'h3FE, 10'h3FF, 4, 0);
        tick(); cfg_valid = 0;
        wait_done(0);
        chk("wrap_m3ff", 32'(mem[10'h3FF]), 32'h10);
        chk("wrap_m000", 32'(mem[10'h000]), 32'h20);
        chk("wrap_m001", 32'(mem[10'h001]), 32'h30);
        chk("wrap_m002", 32'(mem[10'h002]), 32'h40);
        issue(10'h020, 10'h120, 0, 1);
        tick(); cfg_len = 5;
        tick(); cfg_valid = 0;
        repeat (3) tick();
        chk("zero_done_lat", m_done_cyc - m_acc, 1);
        issue(10'h200, 10'h280, 8, 1);
        tick(); cfg_valid = 0;
        tick();
        tick(); reset = 1;
        tick(); reset = 0;
        repeat (4) tick();
        chk("rst_busy", 32'(busy), 0);
        issue(10'h200, 10'h280, 8, 1);
        tick(); cfg_valid = 0;
        wait_done(0);
        issue(10'h040, 10'h140, 2, 2);
        tick();
        issue(10'h050, 10'h150, 3, 3);
        tick(); cfg_valid = 0;
        chk("b2b_gap", m_gap, 1);
        chk("b2b_typ", 32'(act_func_typ), 3);
        wait_done(0);
        for (int j = 0; j < 25; j++) begin
            s = $urandom_range(0, 1023);
            d = $urandom_range(0, 3) == 0 ? s : (s + 100 + $urandom_range(0, 800)) % 1024;
            issue(s, d, $urandom_range(0, 40), $urandom_range(0, 7));
            tick(); cfg_valid = 0;
            wait_done(1);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/al_accel_act_func_sched.md
Name: al_accel_act_func_sched

Overview:
- Job sequencer for the 8-bit activation-function unit.
- Accepts one job descriptor: source address, destination address, element count and function type.
- Streams elements from the accelerator scratchpad through the activation unit, which is combinational, and writes the results back to the scratchpad.
- Sustains one element per cycle, signals completion with a one-cycle done pulse, and sits between the accelerator command decoder and the shared scratchpad port.

Parameters:
- ADDR_W, 10, scratchpad word-address width; all address arithmetic is modulo 2^ADDR_W.
- LEN_W, 10, width of the element count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enb  in  1  issue enable; 0 stops new reads, in-flight elements still complete
- cfg_valid  in  1  descriptor valid
- cfg_ready  out  1  high only in IDLE
- cfg_src_addr  in  ADDR_W  first source word
- cfg_dst_addr  in  ADDR_W  first destination word
- cfg_len  in  LEN_W  element count; 0 means no-op
- cfg_typ  in  3  function select (0 RELU, 1 RELU6, 2 SIGMOID, 3 TANH)
- mem_rd_en  out  1  scratchpad read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  8  read data, valid the cycle after mem_rd_en
- mem_wr_en  out  1  scratchpad write strobe
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  8  write data, equal to act_func_do
- act_func_di  out  8  operand to activation unit
- act_func_typ  out  3  latched cfg_typ
- act_func_do  in  8  activation unit result (combinational)
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (sampled on a clk edge with reset=1):
  - state IDLE; all counters, pipeline valids and registers cleared.
  - Outputs in the following cycle: cfg_ready=1; busy, done, mem_rd_en, mem_wr_en = 0; all address, data and typ outputs = 0.
  - Reset mid-job discards in-flight elements: no read or write occurs after the reset edge.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - Accept when cfg_valid && cfg_ready; latch src, dst, len and typ.
  - Next state RUN if len != 0, else DONE.
  - cfg_valid is ignored in every other state.
- RUN:
  - In each cycle with enb=1: mem_rd_en=1, mem_rd_addr = src + rd_idx, then rd_idx++.
  - When enb=0: mem_rd_en=0 and rd_idx holds.
  - After the read with rd_idx = len-1 is issued, next state is DRAIN.
- Pipeline, for a read in cycle c:
  - End of c+1: di_q <= mem_rd_data, captured regardless of enb.
  - Cycle c+2: act_func_di = di_q, mem_wr_en=1, mem_wr_addr = dst + wr_idx, mem_wr_data = act_func_do, wr_idx++.
  - Elements are written strictly in order. Read-to-write latency is exactly 2 cycles.
- DRAIN: wait until the write with wr_idx = len-1 completes, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy covers RUN, DRAIN and DONE.
- Timing for a job of length N accepted in cycle 0 with enb held at 1:
  - Reads in cycles 1..N, writes in cycles 3..N+2, done in cycle N+3.
  - cfg_ready returns in cycle N+4.
- Zero-length job accepted in cycle 0: done in cycle 1, no memory access.
- act_func_typ holds the latched type from acceptance until the next accept; types 4-7 are forwarded unchanged.
- Address wrap: src+i and dst+i wrap at 2^ADDR_W with no error.
- Overlapping source and destination ranges are allowed. A write never precedes the read of the same index, so in-place operation (src == dst) is correct.

Test Plan:
- RELU job, src=0x010 holding {0x05,0xF0,0x7F,0x80}, dst=0x100, len=4, enb=1, accepted cycle 0 -> reads 0x010-0x013 in cycles 1-4; writes 0x05,0x00,0x7F,0x00 to 0x100-0x103 in cycles 3-6; done pulse in cycle 7; cfg_ready=1 in cycle 8.
- Same job with enb=0 in cycles 2-3 -> no mem_rd_en in cycles 2-3; reads resume at 0x011; identical write data and addresses, in order; done in cycle 9; exactly 4 writes.
- Wrap: src=0x3FE, dst=0x3FF, len=4 -> read addresses 0x3FE,0x3FF,0x000,0x001; write addresses 0x3FF,0x000,0x001,0x002.
- len=0 accepted in cycle 0 -> done=1 in cycle 1; no mem_rd_en or mem_wr_en; cfg_ready=1 in cycle 2. A second cfg_valid while busy is not accepted.
- reset=1 at the edge ending cycle 3 of an N=8 RELU6 job -> from cycle 4: mem_rd_en=0, mem_wr_en=0, busy=0, done=0, cfg_ready=1; no later writes; a new job then runs normally.
- Back-to-back: job A (typ SIGMOID, len=2) then job B (typ TANH, len=3) with cfg_valid held -> B accepted in cycle A.done+1; act_func_typ switches only at B's acceptance; each write matches the activation-unit reference model.
